// File: rtl/heartbeat_ctrl_pkg.sv
// Shared definitions for the heartbeat blink controller: register map,
// field positions and FSM state encoding.
package heartbeat_ctrl_pkg;

  localparam logic [3:0] CTRL_OFS   = 4'h0;
  localparam logic [3:0] PERIOD_OFS = 4'h4;
  localparam logic [3:0] COUNT_OFS  = 4'h8;
  localparam logic [3:0] STATUS_OFS = 4'hC;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_BURST_BIT  = 1;
  localparam int CTRL_IE_BIT     = 2;
  localparam int CTRL_NBEATS_LSB = 8;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  localparam int BEAT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } hb_state_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/heartbeat_ctrl_regs.sv
// Wishbone slave and register file for the heartbeat controller: decode,
// single-cycle ack, byte-enabled writes, DONE write-one-to-clear.
module heartbeat_ctrl_regs
  import heartbeat_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DIV_W     = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              busy,
  input  logic              done_set,
  input  logic [BEAT_W-1:0] beat_count,
  output logic              ctrl_en,
  output logic              ctrl_burst,
  output logic              ctrl_ie,
  output logic [BEAT_W-1:0] ctrl_nbeats,
  output logic [DIV_W-1:0]  period_half,
  output logic              status_done,
  output logic              start_req,
  output logic              stop_req
);

  logic              ack_q, ack_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              en_q, en_d;
  logic              burst_q, burst_d;
  logic              ie_q, ie_d;
  logic [BEAT_W-1:0] nbeats_q, nbeats_d;
  logic [DIV_W-1:0]  half_q, half_d;
  logic              done_q, done_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;

  logic              in_win;
  logic              req;
  logic              wr_req;
  logic              rd_req;
  logic [3:0]        ofs;
  logic [31:0]       wmask;
  logic [31:0]       period_new;
  logic [31:0]       rdata;
  logic              done_clr;
  logic              unused_bits;

  // A request is only taken while ack is low, which enforces the idle
  // cycle between back-to-back transfers.
  always_comb begin
    in_win     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    req        = wbs_cyc_i & wbs_stb_i & ~ack_q & in_win;
    wr_req     = req & wbs_we_i;
    rd_req     = req & ~wbs_we_i;
    ofs        = wbs_adr_i[3:0];
    wmask      = byte_mask(wbs_sel_i);
    period_new = (32'(half_q) & ~wmask) | (wbs_dat_i & wmask);

    rdata = '0;
    case (ofs)
      CTRL_OFS: begin
        rdata[CTRL_EN_BIT]                      = en_q;
        rdata[CTRL_BURST_BIT]                   = burst_q;
        rdata[CTRL_IE_BIT]                      = ie_q;
        rdata[CTRL_NBEATS_LSB +: BEAT_W]        = nbeats_q;
      end
      PERIOD_OFS: rdata = 32'(half_q);
      COUNT_OFS:  rdata[BEAT_W-1:0] = beat_count;
      STATUS_OFS: begin
        rdata[STATUS_BUSY_BIT] = busy;
        rdata[STATUS_DONE_BIT] = done_q;
      end
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    en_d     = en_q;
    burst_d  = burst_q;
    ie_d     = ie_q;
    nbeats_d = nbeats_q;
    half_d   = half_q;
    start_d  = 1'b0;
    stop_d   = 1'b0;
    done_clr = 1'b0;

    if (wr_req) begin
      case (ofs)
        CTRL_OFS: begin
          if (wbs_sel_i[0]) begin
            en_d    = wbs_dat_i[CTRL_EN_BIT];
            burst_d = wbs_dat_i[CTRL_BURST_BIT];
            ie_d    = wbs_dat_i[CTRL_IE_BIT];
            start_d = wbs_dat_i[CTRL_EN_BIT];
            stop_d  = ~wbs_dat_i[CTRL_EN_BIT];
          end
          if (wbs_sel_i[1]) begin
            nbeats_d = wbs_dat_i[CTRL_NBEATS_LSB +: BEAT_W];
          end
        end
        PERIOD_OFS: half_d   = period_new[DIV_W-1:0];
        STATUS_OFS: done_clr = wbs_sel_i[0] & wbs_dat_i[STATUS_DONE_BIT];
        default: ;
      endcase
    end

    // A set from the FSM in the same cycle as a software clear wins.
    done_d = (done_q & ~done_clr) | done_set;
    ack_d  = req;
    rdat_d = rd_req ? rdata : '0;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      en_q     <= 1'b0;
      burst_q  <= 1'b0;
      ie_q     <= 1'b0;
      nbeats_q <= '0;
      half_q   <= '0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      en_q     <= en_d;
      burst_q  <= burst_d;
      ie_q     <= ie_d;
      nbeats_q <= nbeats_d;
      half_q   <= half_d;
      done_q   <= done_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
    end
  end

  assign unused_bits = ^period_new;

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = rdat_q;
  assign ctrl_en     = en_q;
  assign ctrl_burst  = burst_q;
  assign ctrl_ie     = ie_q;
  assign ctrl_nbeats = nbeats_q;
  assign period_half = half_q;
  assign status_done = done_q;
  assign start_req   = start_q;
  assign stop_req    = stop_q;

endmodule

// File: rtl/heartbeat_ctrl.sv
// Programmable heartbeat blink generator: free-run or burst-of-N toggling
// of the pad output, with beat counter and completion interrupt.
module heartbeat_ctrl
  import heartbeat_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DIV_W     = 16
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        out,
  output logic        oeb,
  output logic        irq
);

  logic              ctrl_en;
  logic              ctrl_burst;
  logic              ctrl_ie;
  logic [BEAT_W-1:0] ctrl_nbeats;
  logic [DIV_W-1:0]  period_half;
  logic              status_done;
  logic              start_req;
  logic              stop_req;
  logic              done_set;
  logic              launch;

  hb_state_e         state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  half_act_q, half_act_d;
  logic              out_q, out_d;
  logic [BEAT_W-1:0] count_q, count_d;
  logic              irq_q, irq_d;

  heartbeat_ctrl_regs #(
    .BASE_ADDR (BASE_ADDR),
    .DIV_W     (DIV_W)
  ) u_regs (
    .clk         (clk),
    .nreset      (nreset),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .busy        (state_q == ST_RUN),
    .done_set    (done_set),
    .beat_count  (count_q),
    .ctrl_en     (ctrl_en),
    .ctrl_burst  (ctrl_burst),
    .ctrl_ie     (ctrl_ie),
    .ctrl_nbeats (ctrl_nbeats),
    .period_half (period_half),
    .status_done (status_done),
    .start_req   (start_req),
    .stop_req    (stop_req)
  );

  // The active half-period is only re-sampled from PERIOD at a toggle, so
  // a PERIOD write never stretches or cuts the half-period in progress.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    half_act_d = half_act_q;
    out_d      = out_q;
    count_d    = count_q;
    done_set   = 1'b0;
    launch     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        launch = start_req;
      end
      ST_RUN: begin
        if (stop_req) begin
          state_d = ST_IDLE;
          out_d   = 1'b0;
        end else if (div_q == half_act_q) begin
          div_d      = '0;
          half_act_d = period_half;
          out_d      = ~out_q;
          if (!out_q) begin
            count_d = count_q + 1'b1;
          end else if (ctrl_burst && (count_q == ctrl_nbeats)) begin
            state_d  = ST_DONE;
            done_set = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (stop_req) begin
          state_d = ST_IDLE;
          out_d   = 1'b0;
        end else begin
          launch = start_req;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = 1'b0;
      end
    endcase

    if (launch) begin
      state_d    = ST_RUN;
      div_d      = '0;
      count_d    = '0;
      out_d      = 1'b0;
      half_act_d = period_half;
    end

    irq_d = status_done & ctrl_ie;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      half_act_q <= '0;
      out_q      <= 1'b0;
      count_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      half_act_q <= half_act_d;
      out_q      <= out_d;
      count_q    <= count_d;
      irq_q      <= irq_d;
    end
  end

  assign out = out_q;
  assign oeb = ~ctrl_en;
  assign irq = irq_q;

endmodule

// File: tb/tb_heartbeat_ctrl.sv
// Directed and randomized bench for heartbeat_ctrl against an arithmetic
// model of the blink waveform, beat count and completion flag.
module tb_heartbeat_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] O_CTRL = 32'h0, O_PERIOD = 32'h4, O_COUNT = 32'h8, O_STATUS = 32'hC;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        out, oeb, irq;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int ack_cyc = 0;
  int run_start = 0;

  heartbeat_ctrl #(.BASE_ADDR(BASE), .DIV_W(16)) dut (
    .clk(clk), .nreset(nreset),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .out(out), .oeb(oeb), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  function automatic int beats_of(input int n);
    return (n == 0) ? 256 : n;
  endfunction

  function automatic int eff_phase(input int k, input int h, input int n, input bit burst);
    int p;
    if (k < 0) return 0;
    p = k / (h + 1);
    if (burst && p > 2 * beats_of(n)) p = 2 * beats_of(n);
    return p;
  endfunction

  function automatic logic m_out(input int k, input int h, input int n, input bit burst);
    return (eff_phase(k, h, n, burst) % 2) == 1;
  endfunction

  function automatic int m_count(input int k, input int h, input int n, input bit burst);
    return ((eff_phase(k, h, n, burst) + 1) / 2) % 256;
  endfunction

  function automatic logic m_done(input int k, input int h, input int n, input bit burst);
    if (!burst || k < 0) return 1'b0;
    return (k / (h + 1)) >= 2 * beats_of(n);
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                    input logic [3:0] sel, output logic [31:0] rd, output logic acked);
    acked = 1'b0;
    rd = '0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wbs_ack_o === 1'b1) begin
        acked = 1'b1;
        rd = wbs_dat_o;
        ack_cyc = cyc_n;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] ofs, input logic [31:0] v, input string tag);
    logic [31:0] d;
    logic a;
    wb(BASE + ofs, 1'b1, v, 4'hF, d, a);
    chk({tag, "_ack"}, a, 1);
  endtask

  task automatic rd(input logic [31:0] ofs, input string tag, output logic [31:0] d);
    logic a;
    wb(BASE + ofs, 1'b0, '0, 4'hF, d, a);
    chk({tag, "_ack"}, a, 1);
  endtask

  task automatic start_run(input logic [31:0] ctrl, input string tag);
    wr(O_CTRL, ctrl, tag);
    run_start = ack_cyc + 1;
  endtask

  task automatic run_check(input int cycles, input string tag, input int h, input int n,
                           input bit burst, input bit ie);
    int k;
    for (int i = 0; i < cycles; i++) begin
      step();
      k = cyc_n - run_start;
      chk({tag, "_out"}, out, m_out(k, h, n, burst));
      chk({tag, "_irq"}, irq, ie && (k >= 1) && m_done(k - 1, h, n, burst));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic        a;
    logic        seen;
    int          h, n, ie, k, rise_c, fall_c, rise2_c;

    // reset
    repeat (3) step();
    chk("rst_out", out, 0);
    chk("rst_oeb", oeb, 1);
    chk("rst_irq", irq, 0);
    chk("rst_ack", wbs_ack_o, 0);
    chk("rst_dat", wbs_dat_o, 0);
    #2 nreset = 1'b1;
    step();
    rd(O_CTRL, "rst_ctrl", d);     chk("rst_ctrl", d, 0);
    rd(O_PERIOD, "rst_period", d); chk("rst_period", d, 0);
    rd(O_COUNT, "rst_count", d);   chk("rst_count", d, 0);
    rd(O_STATUS, "rst_status", d); chk("rst_status", d, 0);

    // free-run, HALF=3, then past 256 beats
    wr(O_PERIOD, 3, "fr_period");
    start_run(32'h1, "fr_ctrl");
    chk("fr_oeb", oeb, 0);
    run_check(40, "fr", 3, 0, 1'b0, 1'b0);
    rd(O_COUNT, "fr_count40", d);
    chk("fr_count40", d, m_count(ack_cyc - 1 - run_start, 3, 0, 1'b0));
    while (cyc_n < run_start + 2047) step();
    rd(O_COUNT, "fr_wrap", d);
    chk("fr_wrap", d, m_count(ack_cyc - 1 - run_start, 3, 0, 1'b0));
    rd(O_STATUS, "fr_status", d);
    chk("fr_status", d, 1);
    wr(O_CTRL, 0, "fr_stop");
    step();
    chk("stop_out", out, 0);
    chk("stop_oeb", oeb, 1);
    rd(O_STATUS, "stop_status", d);
    chk("stop_status", d, 0);

    // burst of 4 with interrupt
    wr(O_PERIOD, 1, "bu_period");
    start_run(32'h0407, "bu_ctrl");
    run_check(24, "bu", 1, 4, 1'b1, 1'b1);
    rd(O_STATUS, "bu_status", d); chk("bu_status", d, 2);
    rd(O_COUNT, "bu_count", d);   chk("bu_count", d, m_count(ack_cyc - 1 - run_start, 1, 4, 1'b1));
    chk("bu_irq_hi", irq, 1);
    wr(O_STATUS, 2, "bu_w1c");
    step(); step();
    chk("bu_irq_lo", irq, 0);
    rd(O_STATUS, "bu_status_clr", d); chk("bu_status_clr", d, 0);

    // randomized bursts, each restarted from DONE
    for (int t = 0; t < 4; t++) begin
      h  = $urandom_range(0, 4);
      n  = $urandom_range(1, 6);
      ie = $urandom_range(0, 1);
      wr(O_STATUS, 2, "rb_w1c");
      wr(O_PERIOD, h, "rb_period");
      start_run((n << 8) | (ie << 2) | 3, "rb_ctrl");
      run_check(2 * n * (h + 1) + 4, "rb", h, n, 1'b1, ie[0]);
      rd(O_COUNT, "rb_count", d);
      k = ack_cyc - 1 - run_start;
      chk("rb_count", d, m_count(k, h, n, 1'b1));
      rd(O_STATUS, "rb_status", d);
      k = ack_cyc - 1 - run_start;
      chk("rb_status", d, {30'b0, m_done(k, h, n, 1'b1), !m_done(k, h, n, 1'b1)});
    end

    // NBEATS=0 in burst mode means 256 beats
    wr(O_STATUS, 2, "b256_w1c");
    wr(O_PERIOD, 0, "b256_period");
    start_run(32'h0007, "b256_ctrl");
    run_check(520, "b256", 0, 0, 1'b1, 1'b1);
    rd(O_STATUS, "b256_status", d); chk("b256_status", d, 2);

    // mid-run PERIOD change 2 -> 9
    wr(O_CTRL, 0, "mp_stop");
    wr(O_STATUS, 2, "mp_w1c");
    wr(O_PERIOD, 2, "mp_period_a");
    start_run(32'h1, "mp_ctrl");
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin step(); seen = (out === 1'b1); end
    chk("mp_rise_seen", seen, 1);
    rise_c = cyc_n;
    wr(O_PERIOD, 9, "mp_period_b");
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin step(); seen = (out === 1'b0); end
    chk("mp_fall_seen", seen, 1);
    fall_c = cyc_n;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin step(); seen = (out === 1'b1); end
    chk("mp_rise2_seen", seen, 1);
    rise2_c = cyc_n;
    chk("mp_hi_len", fall_c - rise_c, 2 + 1);
    chk("mp_lo_len", rise2_c - fall_c, 9 + 1);

    // bus behaviour
    wr(O_CTRL, 0, "bus_stop");
    wb(BASE + O_CTRL, 1'b1, 32'hFFFF_FFFF, 4'b0010, d, a);
    chk("bus_bytewr_ack", a, 1);
    rd(O_CTRL, "bus_ctrl", d); chk("bus_ctrl", d, 32'h0000_FF00);
    step();
    chk("bus_bytewr_oeb", oeb, 1);
    chk("bus_bytewr_out", out, 0);
    wb(BASE + 32'h10, 1'b0, '0, 4'hF, d, a);
    chk("bus_oow_ack", a, 0);
    wb(BASE + 32'h2, 1'b0, '0, 4'hF, d, a);
    chk("bus_unmap_ack", a, 1);
    chk("bus_unmap_dat", d, 0);
    wb(BASE + 32'h6, 1'b1, 32'hFFFF_FFFF, 4'hF, d, a);
    chk("bus_unmap_wr_ack", a, 1);
    rd(O_PERIOD, "bus_period", d); chk("bus_period", d, 9);
    wb(BASE + O_PERIOD, 1'b1, 32'h1234_56AB, 4'b0001, d, a);
    rd(O_PERIOD, "bus_period_b0", d); chk("bus_period_b0", d, 32'h0000_00AB);
    step();
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = BASE + O_COUNT; wbs_sel_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("bus_b2b_ack", wbs_ack_o, (i % 2) == 0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    step();

    // asynchronous reset in the middle of a burst
    wr(O_PERIOD, 1, "ar_period");
    start_run(32'h0207, "ar_ctrl_a");
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin step(); seen = (irq === 1'b1); end
    chk("ar_irq_seen", seen, 1);
    start_run(32'h0807, "ar_ctrl_b");
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin step(); seen = (out === 1'b1); end
    chk("ar_out_seen", seen, 1);
    chk("ar_irq_kept", irq, 1);
    #2 nreset = 1'b0;
    #1;
    chk("ar_out", out, 0);
    chk("ar_irq", irq, 0);
    chk("ar_oeb", oeb, 1);
    repeat (2) @(posedge clk);
    #3 nreset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin step(); if (out !== 1'b0) seen = 1'b1; end
    chk("ar_quiet", seen, 0);
    rd(O_CTRL, "ar_ctrl", d);     chk("ar_ctrl", d, 0);
    rd(O_STATUS, "ar_status", d); chk("ar_status", d, 0);
    wr(O_PERIOD, 0, "re_period");
    start_run(32'h1, "re_ctrl");
    run_check(8, "re", 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
